// File: rtl/usb4_prbs_os_gen_pkg.sv
// usb4_prbs_pkg
//   Shared types and constants for the USB4 PRBS ordered-set generator:
//   polynomial-select and FSM state enums, per-lane seeds, feedback taps,
//   and helpers mapping a mode to its seed, tap positions and active mask.
//   The reserved mode maps onto PRBS11 everywhere.
package usb4_prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS11 = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS31 = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned LFSR_W = 31;

  localparam logic [LFSR_W-1:0] SEED11_L0 = 31'h0000_07FF;
  localparam logic [LFSR_W-1:0] SEED11_L1 = 31'h0000_0770;
  localparam logic [LFSR_W-1:0] SEED15_L0 = 31'h0000_7FFF;
  localparam logic [LFSR_W-1:0] SEED15_L1 = 31'h0000_7770;
  localparam logic [LFSR_W-1:0] SEED31_L0 = 31'h7FFF_FFFF;
  localparam logic [LFSR_W-1:0] SEED31_L1 = 31'h7777_7770;

  // Feedback taps; the high tap is also the output bit.
  localparam logic [4:0] TAP11_HI = 5'd10;
  localparam logic [4:0] TAP11_LO = 5'd8;
  localparam logic [4:0] TAP15_HI = 5'd14;
  localparam logic [4:0] TAP15_LO = 5'd13;
  localparam logic [4:0] TAP31_HI = 5'd30;
  localparam logic [4:0] TAP31_LO = 5'd27;

  function automatic logic [LFSR_W-1:0] seed_f(input mode_e m, input logic lane);
    case (m)
      MODE_PRBS15: return lane ? SEED15_L1 : SEED15_L0;
      MODE_PRBS31: return lane ? SEED31_L1 : SEED31_L0;
      default:     return lane ? SEED11_L1 : SEED11_L0;
    endcase
  endfunction

  function automatic logic [4:0] tap_hi_f(input mode_e m);
    case (m)
      MODE_PRBS15: return TAP15_HI;
      MODE_PRBS31: return TAP31_HI;
      default:     return TAP11_HI;
    endcase
  endfunction

  function automatic logic [4:0] tap_lo_f(input mode_e m);
    case (m)
      MODE_PRBS15: return TAP15_LO;
      MODE_PRBS31: return TAP31_LO;
      default:     return TAP11_LO;
    endcase
  endfunction

  // Keeps bits above the active polynomial length at zero.
  function automatic logic [LFSR_W-1:0] mask_f(input mode_e m);
    case (m)
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS31: return 31'h7FFF_FFFF;
      default:     return 31'h0000_07FF;
    endcase
  endfunction

endpackage

// File: rtl/usb4_prbs_os_gen_prbs_step.sv
// prbs_step
//   Combinational multi-step Fibonacci LFSR (shift left, new bit into bit 0).
//   Ports:
//     lfsr_i  current 31-bit LFSR state
//     mode_i  polynomial select
//     lfsr_o  state advanced DATA_W steps
//     bits_o  the DATA_W output bits, MSB first in time
module prbs_step
  import usb4_prbs_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [LFSR_W-1:0] lfsr_i,
  input  mode_e             mode_i,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [DATA_W-1:0] bits_o
);

  logic [4:0]        hi;
  logic [4:0]        lo;
  logic [LFSR_W-1:0] msk;
  logic [LFSR_W-1:0] r;

  assign hi  = tap_hi_f(mode_i);
  assign lo  = tap_lo_f(mode_i);
  assign msk = mask_f(mode_i);

  always_comb begin
    r      = lfsr_i;
    bits_o = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      bits_o[DATA_W-1-i] = r[hi];
      r = {r[LFSR_W-2:0], r[hi] ^ r[lo]} & msk;
    end
    lfsr_o = r;
  end

endmodule

// File: rtl/usb4_prbs_os_gen.sv
// usb4_prbs_os_gen
//   PRBS training ordered-set generator for USB4 lane initialisation.
//   Emits DATA_W PRBS bits per accepted beat, frames OS_LEN-bit ordered sets
//   and counts completed sets.
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     enable           level-sensitive run request
//     mode[1:0]        0 PRBS11, 1 PRBS15, 2 PRBS31, 3 reserved (PRBS11)
//     out_ready        downstream accepts the beat
//     out_valid        beat presented (RUN only)
//     data_out         beat, MSB first in time
//     os_sent          pulse on acceptance of the last beat of a set
//     os_count         completed sets this run, saturating
//     busy             high in LOAD or RUN
module usb4_prbs_os_gen
  import usb4_prbs_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANE   = 0,
  parameter int unsigned OS_LEN = 448,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              os_sent,
  output logic [CNT_W-1:0]  os_count,
  output logic              busy
);

  localparam int unsigned BEATS    = OS_LEN / DATA_W;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic        LANE_SEL = (LANE != 0);

  state_e              state_q;
  mode_e               mode_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_d;
  logic [DATA_W-1:0]   bits_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [CNT_W-1:0]    os_count_q;
  logic                out_valid_q;
  logic                busy_q;
  mode_e               mode_in;
  logic                accept;
  logic                last_beat;

  assign mode_in = mode_e'(mode);

  // The step network only ever sees the mode latched in LOAD, so mode
  // changes during RUN cannot disturb the sequence.
  prbs_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .lfsr_i(lfsr_q),
    .mode_i(mode_q),
    .lfsr_o(lfsr_d),
    .bits_o(bits_d)
  );

  assign accept    = out_valid_q & out_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_PRBS11;
      lfsr_q      <= seed_f(MODE_PRBS11, LANE_SEL);
      beat_q      <= '0;
      os_count_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lfsr_q <= seed_f(mode_in, LANE_SEL);
          if (enable) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          mode_q     <= mode_in;
          lfsr_q     <= seed_f(mode_in, LANE_SEL);
          beat_q     <= '0;
          os_count_q <= '0;
          if (enable) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // A beat accepted in the same cycle enable falls still counts.
          if (accept) begin
            lfsr_q <= lfsr_d;
            if (last_beat) begin
              beat_q <= '0;
              if (os_count_q != '1) os_count_q <= os_count_q + 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
          if (!enable) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = out_valid_q ? bits_d : '0;
  assign os_sent   = accept & last_beat;
  assign os_count  = os_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb4_prbs_os_gen.sv
// Testbench for usb4_prbs_os_gen: expected beats come from a bit-level
// recurrence model of each polynomial; a monitor pops them on every handshake.
module tb_usb4_prbs_os_gen;

  localparam int unsigned DW    = 8;
  localparam int unsigned OSL   = 448;
  localparam int unsigned CW    = 16;
  localparam int unsigned BEATS = OSL / DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          out_valid, os_sent, busy;
  logic [DW-1:0] data_out;
  logic [CW-1:0] os_count;
  logic          out_valid1, os_sent1, busy1;
  logic [DW-1:0] data_out1;
  logic [CW-1:0] os_count1;

  always #5 clk = ~clk;

  usb4_prbs_os_gen #(.DATA_W(DW), .LANE(0), .OS_LEN(OSL), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .os_sent(os_sent),
    .os_count(os_count), .busy(busy)
  );

  usb4_prbs_os_gen #(.DATA_W(DW), .LANE(1), .OS_LEN(OSL), .CNT_W(CW)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid1), .data_out(data_out1), .os_sent(os_sent1),
    .os_count(os_count1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          os;
  } exp_t;

  exp_t sb[$];
  bit   mbits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane-0 sequence from s[n+L] = s[n] ^ s[n+d], seed MSB first.
  function automatic void gen_bits(input int m, input int nbits);
    int L, d;
    logic [31:0] seed;
    case (m)
      1:       begin L = 15; d = 1; seed = 32'h0000_7FFF; end
      2:       begin L = 31; d = 3; seed = 32'h7FFF_FFFF; end
      default: begin L = 11; d = 2; seed = 32'h0000_07FF; end
    endcase
    mbits.delete();
    for (int i = 0; i < nbits; i++) begin
      if (i < L) mbits.push_back(seed[L-1-i]);
      else       mbits.push_back(mbits[i-L] ^ mbits[i-L+d]);
    end
  endfunction

  task automatic push_run(input int m, input int n);
    exp_t e;
    gen_bits(m, n * DW);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < DW; k++) e.data[DW-1-k] = mbits[b*DW+k];
      e.os = ((b + 1) % BEATS == 0);
      sb.push_back(e);
    end
  endtask

  task automatic set_lit(input int idx, input logic [DW-1:0] v);
    exp_t e;
    e = sb[idx];
    e.data = v;
    sb[idx] = e;
  endtask

  task automatic run(input int m, input int n, input int stall_pct,
                     input bit drop_last, input bit toggle, input bit lane1_chk);
    int cnt, guard;
    @(posedge clk); #1;
    mode = 2'(m); enable = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_no_valid", out_valid, 0);
    @(negedge clk);
    check("run_valid", out_valid, 1);
    if (lane1_chk) check("lane1_first_beat", data_out1, 8'hEE);
    cnt = 0;
    guard = 0;
    while (cnt < n && guard < 20000) begin
      @(posedge clk); #1;
      if (toggle) mode = 2'($urandom_range(0, 3));
      if (drop_last && cnt == n - 1) begin
        enable = 1'b0;
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
      guard++;
    end
    if (cnt < n) check("run_timeout", cnt, n);
    @(posedge clk); #1;
    enable = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_data", data_out, 0);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [DW-1:0] prev_data;
    bit            prev_stall;
    exp_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && out_valid) check("stall_hold", data_out, prev_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got beat %0h expected none at %0t", data_out, $time);
        end else begin
          e = sb.pop_front();
          check("beat_data", data_out, e.data);
          check("os_sent", os_sent, e.os);
        end
      end else if (reset) begin
        check("os_sent_quiet", os_sent, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
    end
  end

  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_os_sent", os_sent, 0);
    check("rst_os_count", os_count, 0);
    check("rst_busy", busy, 0);
    check("rst1_valid", out_valid1, 0);
    check("rst1_data", data_out1, 0);
    check("rst1_os_sent", os_sent1, 0);
    check("rst1_os_count", os_count1, 0);
    check("rst1_busy", busy1, 0);
    #22 reset = 1'b1;

    // PRBS11 lane0, no stalls, one full period plus a beat
    push_run(0, 2048);
    set_lit(0, 8'hFF);
    set_lit(1, 8'hE0);
    set_lit(2, 8'h0C);
    set_lit(2047, 8'hFF);
    run(0, 2048, 0, 0, 0, 1);
    check("os_count_A", os_count, 36);

    // Three ordered sets with stalls; enable falls with the final beat
    push_run(0, 168);
    run(0, 168, 40, 1, 0, 0);
    check("os_count_B", os_count, 3);

    // Partial set abandoned; mode toggled during RUN
    push_run(0, 30);
    run(0, 30, 30, 0, 1, 0);
    check("os_count_drop", os_count, 0);

    // PRBS31 after an IDLE->LOAD pass
    push_run(2, 200);
    set_lit(0, 8'hFF);
    run(2, 200, 20, 0, 1, 0);
    check("os_count_D", os_count, 3);

    push_run(1, 120);
    run(1, 120, 25, 0, 0, 0);
    check("os_count_E", os_count, 2);

    // Reserved mode behaves as PRBS11
    push_run(3, 60);
    run(3, 60, 10, 0, 0, 0);
    check("os_count_F", os_count, 1);

    // Asynchronous reset mid-run
    push_run(0, 200);
    @(posedge clk); #1;
    mode = 2'd0; enable = 1'b1; out_ready = 1'b1;
    repeat (70) @(negedge clk);
    check("pre_rst_count", os_count, 1);
    check("pre_rst_busy", busy, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_os_sent", os_sent, 0);
    check("mid_rst_count", os_count, 0);
    check("mid_rst_busy", busy, 0);
    enable = 1'b0; out_ready = 1'b0;
    sb.delete();
    #20 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
